// File: rtl/morse_key_classifier_if.sv
// Signal bundle between the Morse key timing front end and its consumers
// (element shift register and letter/word decoder).
interface morse_key_classifier_if;
    logic       tick;
    logic       key;
    logic       SI;
    logic       shift_en;
    logic [2:0] elem_count;
    logic       letter_done;
    logic       word_done;
    logic       overflow;

    modport master (
        input  tick, key,
        output SI, shift_en, elem_count, letter_done, word_done, overflow
    );

    modport slave (
        output tick, key,
        input  SI, shift_en, elem_count, letter_done, word_done, overflow
    );
endinterface

// File: rtl/morse_key_classifier.sv
// Measures key press/release durations in timebase ticks, emits dot/dash
// elements as serial bits, and flags letter and word boundaries from gap length.
module morse_key_classifier #(
    parameter int CNT_W      = 5,
    parameter int MIN_PRESS  = 1,
    parameter int DOT_MAX    = 3,
    parameter int LETTER_GAP = 6,
    parameter int WORD_GAP   = 14,
    parameter int MAX_ELEM   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    morse_key_classifier_if.master mk
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] MIN_PRESS_C = CNT_W'(MIN_PRESS);
    localparam logic [CNT_W-1:0] DOT_MAX_C   = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] LETTER_END  = CNT_W'(LETTER_GAP - 1);
    localparam logic [CNT_W-1:0] WORD_END    = CNT_W'(WORD_GAP - 1);
    localparam logic [2:0]       MAX_ELEM_C  = 3'(MAX_ELEM);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, WORD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_q, key_d;
    logic [2:0]       elem_q, elem_d;
    logic             si_q, si_d;
    logic             shift_q, shift_d;
    logic             ld_q, ld_d;
    logic             wd_q, wd_d;
    logic             ovf_q, ovf_d;
    logic             rise, fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign rise = mk.key & ~key_q;
    assign fall = ~mk.key & key_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = mk.key;
        elem_d  = elem_q;
        si_d    = si_q;
        shift_d = 1'b0;
        ld_d    = 1'b0;
        wd_d    = 1'b0;
        ovf_d   = ovf_q;

        // The letter's count and overflow stay visible during letter_done.
        if (ld_q) begin
            elem_d = '0;
            ovf_d  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (fall) begin
                    cnt_d = '0;
                    if (cnt_q < MIN_PRESS_C) begin
                        state_d = (elem_q != 3'd0) ? GAP : IDLE;
                    end else begin
                        state_d = GAP;
                        si_d    = (cnt_q > DOT_MAX_C);
                        if (elem_q < MAX_ELEM_C) begin
                            shift_d = 1'b1;
                            elem_d  = elem_q + 3'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end else if (mk.tick) begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            GAP: begin
                if (rise) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end else if (mk.tick) begin
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_q == LETTER_END) begin
                        ld_d    = 1'b1;
                        state_d = WORD;
                    end
                end
            end
            WORD: begin
                if (rise) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end else if (mk.tick) begin
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_q == WORD_END) begin
                        wd_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= 1'b0;
            elem_q  <= '0;
            si_q    <= 1'b0;
            shift_q <= 1'b0;
            ld_q    <= 1'b0;
            wd_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            elem_q  <= elem_d;
            si_q    <= si_d;
            shift_q <= shift_d;
            ld_q    <= ld_d;
            wd_q    <= wd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mk.SI          = si_q;
    assign mk.shift_en    = shift_q;
    assign mk.elem_count  = elem_q;
    assign mk.letter_done = ld_q;
    assign mk.word_done   = wd_q;
    assign mk.overflow    = ovf_q;

endmodule

// File: tb/tb_morse_key_classifier.sv
// Bench for morse_key_classifier: directed and random key/tick traces checked
// cycle by cycle against an interval-based reference model of press and gap timing.
module tb_morse_key_classifier;

    localparam int MIN_PRESS  = 1;
    localparam int DOT_MAX    = 3;
    localparam int LETTER_GAP = 6;
    localparam int WORD_GAP   = 14;
    localparam int MAX_ELEM   = 5;
    localparam int SAT        = 31;
    localparam int N          = 2048;

    logic clk = 1'b0;
    logic reset;
    morse_key_classifier_if mk();

    morse_key_classifier #(
        .CNT_W(5), .MIN_PRESS(MIN_PRESS), .DOT_MAX(DOT_MAX),
        .LETTER_GAP(LETTER_GAP), .WORD_GAP(WORD_GAP), .MAX_ELEM(MAX_ELEM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mk   (mk)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Stimulus trace: value of key/tick sampled at each clock edge.
    bit kv[N];
    bit tv[N];
    int len    = 0;
    int tp     = 1;
    bit rnd_tk = 1'b0;

    // Expected outputs visible in the cycle after each edge.
    bit e_sh[N], e_si[N], e_ld[N], e_wd[N], e_ov[N];
    int e_el[N];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic add(input bit k);
        if (len < N) begin
            kv[len] = k;
            tv[len] = rnd_tk ? ($urandom_range(0, 3) != 0) : ((len % tp) == 0);
            len++;
        end
    endtask

    // Key held through the rise edge plus n ticks; the fall edge follows.
    task automatic press(input int n);
        int c;
        c = 0;
        add(1'b1);
        while (c < n && len < N) begin
            add(1'b1);
            if (tv[len-1]) c++;
        end
    endtask

    // Fall edge plus n further ticks of released key.
    task automatic gap_for(input int n);
        int c;
        c = 0;
        add(1'b0);
        while (c < n && len < N) begin
            add(1'b0);
            if (tv[len-1]) c++;
        end
    endtask

    function automatic int ticks_between(input int a, input int b);
        int s;
        s = 0;
        for (int j = a + 1; j < b; j++) s += int'(tv[j]);
        return s;
    endfunction

    function automatic int nth_tick(input int a, input int n, input int lim);
        int c;
        c = 0;
        for (int j = a + 1; j < lim; j++) begin
            if (tv[j]) begin
                c++;
                if (c == n) return j;
            end
        end
        return -1;
    endfunction

    function automatic int next_rise(input int a);
        for (int j = a + 1; j < len; j++)
            if (kv[j] && !kv[j-1]) return j;
        return len;
    endfunction

    // Each press is a rise..fall interval; each release is fall..next rise.
    function automatic void build_model();
        int el_set[N];
        int ov_set[N];
        int elem, r, d, g, w, nr, cur_el, cur_ov;
        bit prev, open;
        elem = 0;
        r    = 0;
        for (int i = 0; i < len; i++) begin
            e_sh[i] = 0; e_si[i] = 0; e_ld[i] = 0; e_wd[i] = 0;
            el_set[i] = -1; ov_set[i] = -1;
        end
        for (int i = 0; i < len; i++) begin
            prev = (i > 0) ? kv[i-1] : 1'b0;
            if (kv[i] && !prev) r = i;
            if (!kv[i] && prev) begin
                d = ticks_between(r, i);
                if (d > SAT) d = SAT;
                open = 1'b1;
                if (d < MIN_PRESS) begin
                    open = (elem > 0);
                end else if (elem < MAX_ELEM) begin
                    elem++;
                    e_sh[i]   = 1'b1;
                    e_si[i]   = (d > DOT_MAX);
                    el_set[i] = elem;
                end else begin
                    ov_set[i] = 1;
                end
                if (open) begin
                    nr = next_rise(i);
                    g  = nth_tick(i, LETTER_GAP, nr);
                    if (g >= 0) begin
                        e_ld[g] = 1'b1;
                        if (g + 1 < len) begin
                            el_set[g+1] = 0;
                            ov_set[g+1] = 0;
                        end
                        elem = 0;
                        w = nth_tick(i, WORD_GAP, nr);
                        if (w >= 0) e_wd[w] = 1'b1;
                    end
                end
            end
        end
        cur_el = 0;
        cur_ov = 0;
        for (int i = 0; i < len; i++) begin
            if (el_set[i] >= 0) cur_el = el_set[i];
            if (ov_set[i] >= 0) cur_ov = ov_set[i];
            e_el[i] = cur_el;
            e_ov[i] = (cur_ov != 0);
        end
    endfunction

    task automatic run_trace(input string name);
        build_model();
        for (int i = 0; i < len; i++) begin
            mk.key  = kv[i];
            mk.tick = tv[i];
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d].shift_en", name, i), 8'(mk.shift_en), 8'(e_sh[i]));
            check($sformatf("%s[%0d].letter_done", name, i), 8'(mk.letter_done), 8'(e_ld[i]));
            check($sformatf("%s[%0d].word_done", name, i), 8'(mk.word_done), 8'(e_wd[i]));
            check($sformatf("%s[%0d].elem_count", name, i), 8'(mk.elem_count), 8'(e_el[i]));
            check($sformatf("%s[%0d].overflow", name, i), 8'(mk.overflow), 8'(e_ov[i]));
            if (e_sh[i]) check($sformatf("%s[%0d].SI", name, i), 8'(mk.SI), 8'(e_si[i]));
        end
        len = 0;
    endtask

    task automatic do_reset();
        mk.key  = 1'b0;
        mk.tick = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        mk.key  = 1'b0;
        mk.tick = 1'b0;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.shift_en", 8'(mk.shift_en), 8'd0);
        check("reset.SI", 8'(mk.SI), 8'd0);
        check("reset.elem_count", 8'(mk.elem_count), 8'd0);
        check("reset.letter_done", 8'(mk.letter_done), 8'd0);
        check("reset.word_done", 8'(mk.word_done), 8'd0);
        check("reset.overflow", 8'(mk.overflow), 8'd0);
        reset = 1'b0;

        // Reset asserted in the middle of a press after one accepted dot.
        tp = 1;
        press(2); gap_for(2); add(1'b1); add(1'b1); add(1'b1);
        run_trace("pre_reset");
        #2 reset = 1'b1;
        #1;
        check("midreset.shift_en", 8'(mk.shift_en), 8'd0);
        check("midreset.SI", 8'(mk.SI), 8'd0);
        check("midreset.elem_count", 8'(mk.elem_count), 8'd0);
        check("midreset.letter_done", 8'(mk.letter_done), 8'd0);
        check("midreset.word_done", 8'(mk.word_done), 8'd0);
        check("midreset.overflow", 8'(mk.overflow), 8'd0);
        mk.key = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        press(2); gap_for(20);
        run_trace("post_reset");

        // Letter A: dot then dash, full word gap.
        do_reset();
        press(2); gap_for(2); press(5); gap_for(20);
        run_trace("letter_a");

        // Zero-tick glitch after an accepted element.
        do_reset();
        press(2); gap_for(2); press(0); gap_for(20);
        run_trace("glitch");

        // Six dots: the sixth overflows the letter.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            press(2);
            if (i < 5) gap_for(2);
        end
        gap_for(20);
        run_trace("overflow");

        // Dot/dash boundary and counter saturation (34 ticks would wrap to a dot).
        do_reset();
        press(3); gap_for(2); press(4); gap_for(20);
        press(40); gap_for(20);
        press(34); gap_for(20);
        run_trace("boundary");

        // Key rises on exactly the letter-gap tick.
        do_reset();
        press(2); gap_for(LETTER_GAP - 1); press(2); gap_for(20);
        run_trace("rise_vs_gap");

        // Sparse timebase: one tick every fourth cycle.
        do_reset();
        tp = 4;
        press(2); gap_for(2); press(5); gap_for(20);
        run_trace("sparse");

        // Random presses and gaps with an irregular timebase.
        do_reset();
        rnd_tk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            press($urandom_range(0, 7));
            gap_for($urandom_range(0, 18));
        end
        gap_for(20);
        run_trace("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
